mem_arbiter: RTL

- Controller between the CPU's two memory requesters (instruction fetch, data load/store) and the single-ported mainMem.
- Arbitrates, range- and alignment-checks each request, drives one memory access at a time (en/wren/acc_size/addr/d_in), waits on busy, and returns read data with a one-cycle ack.
- Sits between the fetch/memory pipeline stages and mainMem.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_req_check.sv | 51 +++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU memory arbiter and mainMem: FSM states, acc_size codes, window constants.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] START_ADDRESS = 32'h8002_0000;
    localparam int unsigned MEM_SIZE      = 1048576;

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of one access: size code, natural alignment and containment in the mainMem window.
module mem_req_check
    import mem_pkg::*;
#(
    parameter int                    ADDRESS_SIZE  = 32,
    parameter int                    ACCESS_SIZE   = 2,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = ADDRESS_SIZE'(mem_pkg::START_ADDRESS),
    parameter int unsigned           MEM_SIZE      = mem_pkg::MEM_SIZE
) (
    input  logic [ADDRESS_SIZE-1:0] addr,
    input  logic [ACCESS_SIZE-1:0]  size,
    output logic                    ok
);

    logic [ADDRESS_SIZE:0] bytes;
    logic [ADDRESS_SIZE:0] first;
    logic [ADDRESS_SIZE:0] last;
    logic [ADDRESS_SIZE:0] lo;
    logic [ADDRESS_SIZE:0] hi;
    logic                  aligned;
    logic                  size_ok;

    always_comb begin
        bytes   = '0;
        aligned = 1'b0;
        size_ok = 1'b1;
        case (size)
            ACCESS_SIZE'(SIZE_BYTE): begin
                bytes   = (ADDRESS_SIZE+1)'(1);
                aligned = 1'b1;
            end
            ACCESS_SIZE'(SIZE_HALF): begin
                bytes   = (ADDRESS_SIZE+1)'(2);
                aligned = ~addr[0];
            end
            ACCESS_SIZE'(SIZE_WORD): begin
                bytes   = (ADDRESS_SIZE+1)'(4);
                aligned = (addr[1:0] == 2'b00);
            end
            default: size_ok = 1'b0;
        endcase
    end

    // One extra bit keeps addr + bytes - 1 from wrapping at the top of the address space.
    assign first = {1'b0, addr};
    assign last  = first + bytes - (ADDRESS_SIZE+1)'(1);
    assign lo    = {1'b0, START_ADDRESS};
    assign hi    = lo + (ADDRESS_SIZE+1)'(MEM_SIZE);
    assign ok    = size_ok && aligned && (first >= lo) && (last < hi);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto single-ported mainMem, one checked access at a time.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data-over-fetch priority.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int                      ADDRESS_SIZE   = 32,
    parameter int                      DATA_SIZE      = 32,
    parameter int                      ACCESS_SIZE    = 2,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS  = ADDRESS_SIZE'(mem_pkg::START_ADDRESS),
    parameter int unsigned             MEM_SIZE       = mem_pkg::MEM_SIZE,
    parameter int                      TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    output logic                    i_ack,
    output logic [DATA_SIZE-1:0]    i_rdata,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_wren,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [ACCESS_SIZE-1:0]  d_size,
    input  logic [DATA_SIZE-1:0]    d_wdata,
    output logic                    d_ack,
    output logic [DATA_SIZE-1:0]    d_rdata,
    output logic                    d_err,
    output logic                    mem_en,
    output logic                    mem_wren,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_d_in,
    output logic [ACCESS_SIZE-1:0]  mem_acc_size,
    input  logic [DATA_SIZE-1:0]    mem_d_out,
    input  logic                    mem_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    grant_data;
    logic [TW-1:0]           tcnt;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [ACCESS_SIZE-1:0]  size_q;
    logic [DATA_SIZE-1:0]    wdata_q;
    logic [DATA_SIZE-1:0]    rdata_q;
    logic                    wren_q;
    logic                    pick_data;
    logic                    any_req;
    logic                    req_ok;
    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic [ACCESS_SIZE-1:0]  sel_size;
    logic                    active;
    logic                    done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_data;
    assign pick_data = d_req && (!i_req || !last_data);
`else
    assign pick_data = d_req;
`endif

    assign any_req  = d_req | i_req;
    assign sel_addr = pick_data ? d_addr : i_addr;
    assign sel_size = pick_data ? d_size : ACCESS_SIZE'(SIZE_WORD);

    mem_req_check #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .ACCESS_SIZE  (ACCESS_SIZE),
        .START_ADDRESS(START_ADDRESS),
        .MEM_SIZE     (MEM_SIZE)
    ) u_check (
        .addr(sel_addr),
        .size(sel_size),
        .ok  (req_ok)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = req_ok ? ISSUE : ERR;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (!mem_busy)                               state_nxt = RESP;
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1))    state_nxt = ERR;
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_data <= 1'b0;
            tcnt       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) grant_data <= pick_data;
            if (state == ISSUE)           tcnt <= '0;
            else if (state == WAIT)       tcnt <= tcnt + TW'(1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (state == RESP || state == ERR) last_data <= grant_data;
`endif
        end
    end

    // Operand and read-data registers carry no reset; every output path is gated by state.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr_q  <= sel_addr;
            size_q  <= sel_size;
            wdata_q <= pick_data ? d_wdata : '0;
            wren_q  <= pick_data & d_wren;
        end
        if (state == WAIT && !mem_busy) rdata_q <= wren_q ? '0 : mem_d_out;
    end

    assign active       = (state == ISSUE) || (state == WAIT);
    assign done         = (state == RESP) || (state == ERR);
    assign mem_en       = (state == ISSUE);
    assign mem_wren     = active & wren_q;
    assign mem_addr     = active ? addr_q  : '0;
    assign mem_d_in     = active ? wdata_q : '0;
    assign mem_acc_size = active ? size_q  : '0;

    assign i_ack   = done & ~grant_data;
    assign d_ack   = done &  grant_data;
    assign i_err   = (state == ERR) & ~grant_data;
    assign d_err   = (state == ERR) &  grant_data;
    assign i_rdata = (state == RESP && !grant_data) ? rdata_q : '0;
    assign d_rdata = (state == RESP &&  grant_data) ? rdata_q : '0;

endmodule
